// File: rtl/mult_table_pkg.sv
// Shared definitions for the multiplication-table generator: FSM state type,
// default widths and the result-width derivation.
package mult_table_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int MULT_W_DEF = 8;
   localparam int IDX_W_DEF  = 4;

   // M*index < 2^MULT_W * 2^IDX_W, so the sum of the widths never overflows.
   function automatic int res_w(input int mult_w, input int idx_w);
      return mult_w + idx_w;
   endfunction

endpackage

// File: rtl/mult_table_acc.sv
// Row counter and repeated-addition accumulator; result tracks multiplicand*index
// without a multiplier.
module mult_table_acc
   import mult_table_pkg::*;
#(
   parameter int MULT_W = MULT_W_DEF,
   parameter int IDX_W  = IDX_W_DEF,
   parameter int RES_W  = res_w(MULT_W_DEF, IDX_W_DEF)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              step,
   input  logic [MULT_W-1:0] multiplicand,
   input  logic [IDX_W-1:0]  last_index,
   output logic [IDX_W-1:0]  index,
   output logic [RES_W-1:0]  result,
   output logic              at_last
);

   // load wins over step so a wrap or a fresh start always begins at row 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         index  <= '0;
         result <= '0;
      end else if (load) begin
         index  <= '0;
         result <= '0;
      end else if (step) begin
         index  <= index + IDX_W'(1);
         result <= result + RES_W'(multiplicand);
      end
   end

   assign at_last = (index == last_index);

endmodule

// File: rtl/mult_table_gen.sv
// Multiplication-table generator: streams (index, M*index) rows for index 0..L on a
// valid/ready port, with back-pressure, abort and wrap-around repeat.
module mult_table_gen
   import mult_table_pkg::*;
#(
   parameter int MULT_W = MULT_W_DEF,
   parameter int IDX_W  = IDX_W_DEF,
   localparam int RES_W = res_w(MULT_W, IDX_W)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [MULT_W-1:0] multiplicand,
   input  logic [IDX_W-1:0]  last_index,
   input  logic              repeat_en,
   input  logic              abort,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [IDX_W-1:0]  index,
   output logic [RES_W-1:0]  result,
   output logic              last,
   output logic              busy,
   output logic              done
);

   // Handshake: a row transfers on any rising edge where out_valid && out_ready;
   // while out_ready is low the presented row (index, result, last) holds unchanged.

   state_t            state;
   state_t            next_state;
   logic [MULT_W-1:0] mult_q;
   logic [IDX_W-1:0]  last_q;
   logic              repeat_q;
   logic              latch;
   logic              load;
   logic              step;
   logic              done_d;
   logic              at_last;
   logic              accept;

   assign accept = (state == RUN) && out_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         done     <= 1'b0;
         mult_q   <= '0;
         last_q   <= '0;
         repeat_q <= 1'b0;
      end else begin
         state <= next_state;
         done  <= done_d;
         if (latch) begin
            mult_q   <= multiplicand;
            last_q   <= last_index;
            repeat_q <= repeat_en;
         end
      end
   end

   always_comb begin
      next_state = state;
      latch      = 1'b0;
      load       = 1'b0;
      step       = 1'b0;
      done_d     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               latch      = 1'b1;
               load       = 1'b1;
               next_state = RUN;
            end
         end
         RUN: begin
            // Abort beats a simultaneous accept; leaving RUN always clears the counter.
            if (abort) begin
               load       = 1'b1;
               next_state = IDLE;
            end else if (accept) begin
               if (!at_last) begin
                  step = 1'b1;
               end else if (repeat_q) begin
                  load = 1'b1;
               end else begin
                  load       = 1'b1;
                  done_d     = 1'b1;
                  next_state = IDLE;
               end
            end
         end
         default: next_state = IDLE;
      endcase
   end

   mult_table_acc #(
      .MULT_W(MULT_W),
      .IDX_W (IDX_W),
      .RES_W (RES_W)
   ) u_acc (
      .clk         (clk),
      .reset       (reset),
      .load        (load),
      .step        (step),
      .multiplicand(mult_q),
      .last_index  (last_q),
      .index       (index),
      .result      (result),
      .at_last     (at_last)
   );

   assign busy      = (state == RUN);
   assign out_valid = busy;
   assign last      = busy && at_last;

endmodule

// File: tb/tb_mult_table_gen.sv
// Directed bench for mult_table_gen: full tables, widest values, back-pressure,
// single-row restart, repeat with abort, and mid-table reset.
module tb_mult_table_gen;

   localparam int MULT_W = 8;
   localparam int IDX_W  = 4;
   localparam int RES_W  = MULT_W + IDX_W;

   logic              clk;
   logic              reset;
   logic              start;
   logic [MULT_W-1:0] multiplicand;
   logic [IDX_W-1:0]  last_index;
   logic              repeat_en;
   logic              abort;
   logic              out_valid;
   logic              out_ready;
   logic [IDX_W-1:0]  index;
   logic [RES_W-1:0]  result;
   logic              last;
   logic              busy;
   logic              done;

   int checks;
   int failures;

   mult_table_gen #(.MULT_W(MULT_W), .IDX_W(IDX_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .multiplicand(multiplicand),
      .last_index  (last_index),
      .repeat_en   (repeat_en),
      .abort       (abort),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .index       (index),
      .result      (result),
      .last        (last),
      .busy        (busy),
      .done        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_row(input string tag, input int idx, input int res, input bit is_last);
      check_eq({tag, " valid"}, 32'(out_valid), 32'd1);
      check_eq({tag, " index"}, 32'(index), 32'(idx));
      check_eq({tag, " result"}, 32'(result), 32'(res));
      check_eq({tag, " last"}, 32'(last), 32'(is_last));
      check_eq({tag, " busy"}, 32'(busy), 32'd1);
      check_eq({tag, " done"}, 32'(done), 32'd0);
   endtask

   task automatic check_idle(input string tag, input bit exp_done);
      check_eq({tag, " valid"}, 32'(out_valid), 32'd0);
      check_eq({tag, " busy"}, 32'(busy), 32'd0);
      check_eq({tag, " last"}, 32'(last), 32'd0);
      check_eq({tag, " done"}, 32'(done), 32'(exp_done));
   endtask

   task automatic launch(input int m, input int l, input bit rep);
      start        = 1'b1;
      multiplicand = MULT_W'(m);
      last_index   = IDX_W'(l);
      repeat_en    = rep;
      tick();
      start = 1'b0;
   endtask

   // Runs a table at full throughput; ends in the cycle where done should be high.
   task automatic full_table(input string tag, input int m, input int l);
      launch(m, l, 1'b0);
      for (int i = 0; i <= l; i++) begin
         check_row(tag, i, m * i, i == l);
         tick();
      end
      check_idle({tag, " end"}, 1'b1);
   endtask

   initial begin
      checks       = 0;
      failures     = 0;
      reset        = 1'b1;
      start        = 1'b0;
      multiplicand = '0;
      last_index   = '0;
      repeat_en    = 1'b0;
      abort        = 1'b0;
      out_ready    = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      check_idle("reset", 1'b0);
      check_eq("reset index", 32'(index), 32'd0);
      check_eq("reset result", 32'(result), 32'd0);

      // Basic M=3, L=10; done drops after one cycle.
      full_table("basic", 3, 10);
      tick();
      check_idle("basic after", 1'b0);

      // Widest values: last row must be (15, 3825).
      launch(255, 15, 1'b0);
      for (int i = 0; i < 15; i++) tick();
      check_row("max last", 15, 3825, 1'b1);
      tick();
      check_idle("max end", 1'b1);
      tick();

      // Back-pressure at row (4,28) for three cycles.
      launch(7, 8, 1'b0);
      for (int i = 0; i < 4; i++) begin
         check_row("bp pre", i, 7 * i, 1'b0);
         tick();
      end
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check_row("bp hold", 4, 28, 1'b0);
         tick();
      end
      out_ready = 1'b1;
      for (int i = 4; i <= 8; i++) begin
         check_row("bp post", i, 7 * i, i == 8);
         tick();
      end
      check_idle("bp end", 1'b1);
      tick();

      // Single row, then start during done launches the next table.
      full_table("single", 9, 0);
      launch(2, 1, 1'b0);
      check_row("restart r0", 0, 0, 1'b0);
      tick();
      check_row("restart r1", 1, 2, 1'b1);
      tick();
      check_idle("restart end", 1'b1);
      tick();

      // Repeat M=5, L=2, then abort on row (1,5).
      launch(5, 2, 1'b1);
      for (int k = 0; k < 7; k++) begin
         check_row("rep", k % 3, 5 * (k % 3), (k % 3) == 2);
         tick();
      end
      check_row("rep abort row", 1, 5, 1'b0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_idle("rep abort", 1'b0);
      tick();
      check_idle("rep abort later", 1'b0);

      // Ignored start/M changes mid-table, then reset at row (6,18).
      launch(3, 10, 1'b0);
      for (int i = 0; i < 6; i++) begin
         check_row("ign", i, 3 * i, 1'b0);
         if (i == 2) begin
            start        = 1'b1;
            multiplicand = 8'd9;
            last_index   = 4'd3;
         end else begin
            start = 1'b0;
         end
         tick();
      end
      start = 1'b0;
      check_row("ign r6", 6, 18, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      check_idle("midreset", 1'b0);
      check_eq("midreset index", 32'(index), 32'd0);
      check_eq("midreset result", 32'(result), 32'd0);
      #1;
      reset = 1'b0;
      tick();
      check_idle("post reset", 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
